// File: rtl/corr_window_sched_pkg.sv
// Shared types and helpers for the correlation window scheduler.
// Holds the scheduler state encoding, default widths and the exponent-width function.
package corr_window_sched_pkg;

    localparam int TIME_W_DEF = 8;
    localparam int IDX_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ZERO  = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    // Exponent must encode 0..time_w inclusive.
    function automatic int exp_width(input int time_w);
        return $clog2(time_w + 1);
    endfunction

endpackage

// File: rtl/corr_window_sched_timer.sv
// Window timer: clears in IDLE, loads 1 in ZERO, increments in COUNT.
// Flags the terminal count 2^exp-1, which ends the window.
module corr_window_sched_timer
    import corr_window_sched_pkg::*;
#(
    parameter int  TIME_W = TIME_W_DEF,
    localparam int EXP_W  = exp_width(TIME_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [EXP_W-1:0] i_exp,
    output logic             o_terminal
);

    logic [TIME_W-1:0] timer_q;
    logic [TIME_W:0]   span;

    // One extra bit so exp == TIME_W still yields an all-ones terminal value.
    assign span       = (TIME_W + 1)'(1) << i_exp;
    assign o_terminal = ({1'b0, timer_q} == (span - (TIME_W + 1)'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer_q <= '0;
        end else if (i_cg) begin
            if (i_clr) begin
                timer_q <= '0;
            end else if (i_load) begin
                timer_q <= TIME_W'(1);
            end else if (i_inc) begin
                timer_q <= timer_q + TIME_W'(1);
            end
        end
    end

endmodule

// File: rtl/corr_window_sched.sv
// Sequences back-to-back 2^exp-cycle windows for the correlation counter and
// hands completed-window totals downstream through a one-entry result register.
module corr_window_sched
    import corr_window_sched_pkg::*;
#(
    parameter int  TIME_W = TIME_W_DEF,
    parameter int  IDX_W  = IDX_W_DEF,
    localparam int EXP_W  = exp_width(TIME_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cg,
    input  logic              i_en,
    input  logic [EXP_W-1:0]  i_windowLengthExp,
    output logic [EXP_W-1:0]  o_windowLengthExp,
    output logic              o_zeroCounts,
    input  logic [TIME_W-1:0] i_countX,
    input  logic [TIME_W-1:0] i_countY,
    input  logic [TIME_W-1:0] i_countIsect,
    input  logic [TIME_W-1:0] i_countSymdiff,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [TIME_W-1:0] o_countX,
    output logic [TIME_W-1:0] o_countY,
    output logic [TIME_W-1:0] o_countIsect,
    output logic [TIME_W-1:0] o_countSymdiff,
    output logic [IDX_W-1:0]  o_windowIdx,
    output logic              o_dropped,
    input  logic              i_clrDropped,
    output logic [1:0]        o_state
);

    state_t            state_q, state_d;
    logic [EXP_W-1:0]  exp_q;
    logic [EXP_W-1:0]  exp_req;
    logic              exp_load;
    logic              done_q;
    logic              terminal;
    logic              start_ok;
    logic              capture;
    logic              accept;
    logic [IDX_W-1:0]  win_cnt_q;

    assign start_ok = i_en && (i_windowLengthExp != '0);
    assign exp_req  = (i_windowLengthExp > EXP_W'(TIME_W)) ? EXP_W'(TIME_W) : i_windowLengthExp;

    assign o_zeroCounts      = (state_q != ST_COUNT);
    assign o_windowLengthExp = exp_q;
    assign o_state           = state_q;

    corr_window_sched_timer #(
        .TIME_W (TIME_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cg       (i_cg),
        .i_clr      (state_q == ST_IDLE),
        .i_load     (state_q == ST_ZERO),
        .i_inc      (state_q == ST_COUNT),
        .i_exp      (exp_q),
        .o_terminal (terminal)
    );

    always_comb begin
        state_d  = state_q;
        exp_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d  = ST_ZERO;
                    exp_load = 1'b1;
                end
            end
            ST_ZERO: begin
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (terminal) begin
                    if (start_ok) begin
                        state_d  = ST_ZERO;
                        exp_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!i_en) begin
                    // Partial window is abandoned; done stays clear so nothing is captured.
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            done_q  <= 1'b0;
        end else if (i_cg) begin
            state_q <= state_d;
            if (exp_load) begin
                exp_q <= exp_req;
            end
            if ((state_q == ST_COUNT) && terminal) begin
                done_q <= 1'b1;
            end else if (capture) begin
                done_q <= 1'b0;
            end
        end
    end

    // Handshake: a result transfers on an edge with i_cg=1 where o_valid && i_ready.
    // o_valid is registered; a capture may refill the register on the same edge it empties.
    assign capture = o_zeroCounts && done_q;
    assign accept  = !o_valid || i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid        <= 1'b0;
            o_countX       <= '0;
            o_countY       <= '0;
            o_countIsect   <= '0;
            o_countSymdiff <= '0;
            o_windowIdx    <= '0;
            o_dropped      <= 1'b0;
            win_cnt_q      <= '0;
        end else if (i_cg) begin
            if (capture) begin
                win_cnt_q <= win_cnt_q + IDX_W'(1);
                if (accept) begin
                    o_valid        <= 1'b1;
                    o_countX       <= i_countX;
                    o_countY       <= i_countY;
                    o_countIsect   <= i_countIsect;
                    o_countSymdiff <= i_countSymdiff;
                    o_windowIdx    <= win_cnt_q;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (capture && !accept) begin
                o_dropped <= 1'b1;
            end else if (i_clrDropped) begin
                o_dropped <= 1'b0;
            end
        end
    end

endmodule
